// File: rtl/riscv_pkg.sv
// Shared RV32 encoding constants and the field-bundle kind/state encodings
// used by the program loader.
package riscv_pkg;

  localparam logic [6:0] ALU_R     = 7'b0110011;
  localparam logic [6:0] ALU_I     = 7'b0010011;
  localparam logic [6:0] BRANCH_EQ = 7'b1100011;
  localparam logic [6:0] JUMP      = 7'b1101111;
  localparam logic [6:0] LOAD      = 7'b0000011;
  localparam logic [6:0] STORE     = 7'b0100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  localparam logic [31:0] NOP_WORD = 32'h00000013;

  typedef enum logic [2:0] {
    K_R     = 3'd0,
    K_I     = 3'd1,
    K_BEQ   = 3'd2,
    K_JAL   = 3'd3,
    K_LOAD  = 3'd4,
    K_STORE = 3'd5,
    K_MUL   = 3'd6,
    K_ILL   = 3'd7
  } kind_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_PAD  = 2'd2,
    S_DONE = 2'd3
  } ld_state_e;

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: decoded fields -> 32-bit RV word plus an
// immediate-range / legal-kind flag.
module instr_pack
  import riscv_pkg::*;
(
  input  logic [2:0]  kind,
  input  logic [2:0]  funct3,
  input  logic        alt,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        range_ok
);

  logic fit12, fit13, fit21;

  // A value fits in N signed bits when all bits above N-1 match the sign.
  assign fit12 = (&imm[31:11]) | ~(|imm[31:11]);
  assign fit13 = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
  assign fit21 = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];

  always_comb begin
    word     = '0;
    range_ok = 1'b1;
    case (kind)
      K_R:     word = {(alt ? F7_ALT : F7_BASE), rs2, rs1, funct3, rd, ALU_R};
      K_MUL:   word = {F7_MUL, rs2, rs1, funct3, rd, ALU_R};
      K_I: begin
        word     = {imm[11:0], rs1, funct3, rd, ALU_I};
        range_ok = fit12;
      end
      K_LOAD: begin
        word     = {imm[11:0], rs1, funct3, rd, LOAD};
        range_ok = fit12;
      end
      K_STORE: begin
        word     = {imm[11:5], rs2, rs1, funct3, imm[4:0], STORE};
        range_ok = fit12;
      end
      K_BEQ: begin
        word     = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], BRANCH_EQ};
        range_ok = fit13;
      end
      K_JAL: begin
        word     = {imm[20], imm[10:1], imm[11], imm[19:12], rd, JUMP};
        range_ok = fit21;
      end
      default: range_ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: accepts field bundles, writes packed words sequentially
// into instruction memory, and pads the tail with NOPs on finish.
module instr_encoder_loader #(
  parameter int          ADDR_W   = 6,
  parameter int          DEPTH    = 64,
  parameter logic [31:0] NOP_WORD = riscv_pkg::NOP_WORD
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        kind,
  input  logic [2:0]        funct3,
  input  logic              alt,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [31:0]       imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              err
);
  import riscv_pkg::*;

  localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] LAST_C  = DEPTH_C - 1'b1;

  ld_state_e   state, state_n;
  logic        acc, pad_wr;
  logic [31:0] pk_word;
  logic        pk_ok;

  instr_pack u_pack (
    .kind     (kind),
    .funct3   (funct3),
    .alt      (alt),
    .rd       (rd),
    .rs1      (rs1),
    .rs2      (rs2),
    .imm      (imm),
    .word     (pk_word),
    .range_ok (pk_ok)
  );

  always_comb begin
    state_n  = state;
    acc      = 1'b0;
    pad_wr   = 1'b0;
    in_ready = (state == S_LOAD) && (count < DEPTH_C) && !finish;
    if (start) begin
      state_n = S_LOAD;
    end else begin
      case (state)
        S_LOAD: begin
          if (finish) begin
            state_n = (count == DEPTH_C) ? S_DONE : S_PAD;
          end else if (in_valid && in_ready) begin
            acc = 1'b1;
            if (pk_ok && count == LAST_C) state_n = S_DONE;
          end
        end
        S_PAD: begin
          pad_wr = 1'b1;
          if (count == LAST_C) state_n = S_DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state      <= S_IDLE;
      count      <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      err        <= 1'b0;
    end else begin
      state   <= state_n;
      imem_we <= 1'b0;
      if (start) begin
        count     <= '0;
        imem_addr <= '0;
        err       <= 1'b0;
      end else if (acc) begin
        // Rejected bundles are consumed without touching memory or count.
        if (pk_ok) begin
          imem_we    <= 1'b1;
          imem_addr  <= count[ADDR_W-1:0];
          imem_wdata <= pk_word;
          count      <= count + 1'b1;
        end else begin
          err <= 1'b1;
        end
      end else if (pad_wr) begin
        imem_we    <= 1'b1;
        imem_addr  <= count[ADDR_W-1:0];
        imem_wdata <= NOP_WORD;
        count      <= count + 1'b1;
      end
    end
  end

  assign busy = (state == S_LOAD) || (state == S_PAD);
  assign done = (state == S_DONE);

endmodule
